// File: rtl/complex_mul_pipe.sv
// complex_mul_pipe: two-stage signed complex multiplier with valid/ready flow.
// Computes a*b (in_conj=0) or a*conj(b) (in_conj=1) at one sample per cycle.
// Stage 1 registers the four partial products; stage 2 combines, scales and
// holds the result as the output register.
// Optional feature macro: COMPLEX_MUL_ROUND_SAT_EN
//   undefined : floor shift by SHIFT, wrap-around narrowing to OUT_W
//   defined   : round-half-up before the shift, saturate to the OUT_W range
module complex_mul_pipe #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 2*DATA_W+1,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_conj,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  y_re,
  output logic signed [OUT_W-1:0]  y_im
);

  localparam int PW = 2*DATA_W;       // product width
  localparam int FW = PW + 1;         // full-precision sum width
  localparam int WW = FW + OUT_W + 1; // scaling workspace, wide enough for round carry and clamp compare

  localparam logic signed [WW-1:0] SAT_MAX = {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [WW-1:0] SAT_MIN = {{(WW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam int                   RND_SH  = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [WW-1:0] RND     = (SHIFT > 0) ? (WW'(1) <<< RND_SH) : '0;

  // stage 1 registers
  logic signed [PW-1:0] p0_q, p1_q, p2_q, p3_q;
  logic signed [PW-1:0] p0_d, p1_d, p2_d, p3_d;
  logic                 conj_q, conj_d;
  logic                 s1_valid_q, s1_valid_d;

  // stage 2 (output) registers
  logic signed [OUT_W-1:0] y_re_q, y_re_d;
  logic signed [OUT_W-1:0] y_im_q, y_im_d;
  logic                    out_valid_q, out_valid_d;

  logic s1_adv, s2_adv;

  logic signed [FW-1:0] p0_x, p1_x, p2_x, p3_x;
  logic signed [FW-1:0] re_full, im_full;

  // Shift, optionally round, then narrow the full-precision value to OUT_W.
  function automatic logic signed [OUT_W-1:0] scale(input logic signed [FW-1:0] v);
    logic signed [WW-1:0] x;
    x = {{(WW-FW){v[FW-1]}}, v};
`ifdef COMPLEX_MUL_ROUND_SAT_EN
    x = x + RND;
    x = x >>> SHIFT;
    if (x > SAT_MAX)      x = SAT_MAX;
    else if (x < SAT_MIN) x = SAT_MIN;
`else
    x = x >>> SHIFT;
`endif
    return x[OUT_W-1:0];
  endfunction

  // Stage enables: the output register frees up when empty or draining, and
  // stage 1 moves whenever it is empty or stage 2 can take its content.
  always_comb begin
    s2_adv = !out_valid_q || out_ready;
    s1_adv = !s1_valid_q || s2_adv;
  end

  assign in_ready  = s1_adv;
  assign out_valid = out_valid_q;
  assign y_re      = y_re_q;
  assign y_im      = y_im_q;

  // Stage 1 next state: capture products and conj mode on an input transfer.
  always_comb begin
    p0_d       = p0_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    p3_d       = p3_q;
    conj_d     = conj_q;
    s1_valid_d = s1_valid_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        p0_d   = PW'(a_re) * PW'(b_re);
        p1_d   = PW'(a_im) * PW'(b_im);
        p2_d   = PW'(a_re) * PW'(b_im);
        p3_d   = PW'(a_im) * PW'(b_re);
        conj_d = in_conj;
      end
    end
  end

  // Stage 2 datapath: sign-extend products by one bit so the full-scale
  // corner (-2^(DATA_W-1))^2 * 2 is representable, then add/subtract.
  always_comb begin
    p0_x = {p0_q[PW-1], p0_q};
    p1_x = {p1_q[PW-1], p1_q};
    p2_x = {p2_q[PW-1], p2_q};
    p3_x = {p3_q[PW-1], p3_q};
    if (conj_q) begin
      re_full = p0_x + p1_x;
      im_full = p3_x - p2_x;
    end else begin
      re_full = p0_x - p1_x;
      im_full = p2_x + p3_x;
    end
  end

  // Stage 2 next state: load a new result when the output register advances,
  // otherwise hold so a stalled output stays stable.
  always_comb begin
    y_re_d      = y_re_q;
    y_im_d      = y_im_q;
    out_valid_d = out_valid_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        y_re_d = scale(re_full);
        y_im_d = scale(im_full);
      end
    end
  end

  // Pipeline registers with synchronous reset that discards in-flight samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0_q        <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      p3_q        <= '0;
      conj_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      y_re_q      <= '0;
      y_im_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      p3_q        <= p3_d;
      conj_q      <= conj_d;
      s1_valid_q  <= s1_valid_d;
      y_re_q      <= y_re_d;
      y_im_q      <= y_im_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_complex_mul_pipe.sv
// Testbench for complex_mul_pipe: default instance (OUT_W=33, SHIFT=0) plus a
// scaled instance (OUT_W=16, SHIFT=15) sharing the same stimulus.
module tb_complex_mul_pipe;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_conj, out_ready;
  logic signed [15:0] a_re, a_im, b_re, b_im;
  logic in_ready, out_valid;
  logic signed [32:0] y_re, y_im;
  logic in_ready_s, out_valid_s;
  logic signed [15:0] ys_re, ys_im;

  int n_checks = 0;
  int n_fail   = 0;

  longint exp_re_q[$];
  longint exp_im_q[$];

  always #5 clk = ~clk;

  complex_mul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_conj(in_conj),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid), .out_ready(out_ready), .y_re(y_re), .y_im(y_im)
  );

  complex_mul_pipe #(.DATA_W(16), .OUT_W(16), .SHIFT(15)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_conj(in_conj),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid_s), .out_ready(out_ready), .y_re(ys_re), .y_im(ys_im)
  );

  // Reference: textbook complex multiply with b conjugated when c=1.
  function automatic void model(input logic signed [15:0] ar, ai, br, bi, input logic c,
                                output longint er, output longint ei);
    longint bim;
    bim = c ? -longint'(bi) : longint'(bi);
    er  = longint'(ar) * longint'(br) - longint'(ai) * bim;
    ei  = longint'(ar) * bim + longint'(ai) * longint'(br);
  endfunction

  task automatic set_in(input logic signed [15:0] ar, ai, br, bi, input logic c);
    a_re = ar; a_im = ai; b_re = br; b_im = bi; in_conj = c;
  endtask

  // One sample in, then two edges: the result is on the outputs afterwards.
  task automatic send_one(input logic signed [15:0] ar, ai, br, bi, input logic c);
    set_in(ar, ai, br, bi, c);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_in(16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || y_re !== 33'sd0 || y_im !== 33'sd0) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%b y=(%0d,%0d) expected 0,(0,0)", out_valid, y_re, y_im);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic;
    set_in(16'sd3, 16'sd4, 16'sd5, -16'sd2, 1'b0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency_early: out_valid=%b expected 0 after first edge", out_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || y_re !== 33'sd23 || y_im !== 33'sd14) begin
      n_fail++;
      $display("FAIL basic_result: out_valid=%b y=(%0d,%0d) expected 1,(23,14)", out_valid, y_re, y_im);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_no_duplicate: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_conj;
    send_one(16'sd3, 16'sd4, 16'sd5, -16'sd2, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || y_re !== 33'sd7 || y_im !== 33'sd26) begin
      n_fail++;
      $display("FAIL conj_result: out_valid=%b y=(%0d,%0d) expected 1,(7,26)", out_valid, y_re, y_im);
    end
  endtask

  task automatic test_corner;
    logic signed [15:0] exp_s;
`ifdef COMPLEX_MUL_ROUND_SAT_EN
    exp_s = 16'sd32767;
`else
    exp_s = 16'sd0;
`endif
    send_one(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 1'b1);
    n_checks++;
    if (longint'(y_re) !== 64'sd2147483648 || longint'(y_im) !== 64'sd0) begin
      n_fail++;
      $display("FAIL corner_conj: y=(%0d,%0d) expected (2147483648,0)", y_re, y_im);
    end
    n_checks++;
    if (ys_re !== exp_s) begin
      n_fail++;
      $display("FAIL corner_scaled_re: got %0d expected %0d", ys_re, exp_s);
    end
    send_one(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 1'b0);
    n_checks++;
    if (longint'(y_re) !== 64'sd0 || longint'(y_im) !== 64'sd2147483648) begin
      n_fail++;
      $display("FAIL corner_plain: y=(%0d,%0d) expected (0,2147483648)", y_re, y_im);
    end
  endtask

  task automatic test_scaling;
    logic signed [15:0] exp_s;
`ifdef COMPLEX_MUL_ROUND_SAT_EN
    exp_s = 16'sd16384;
`else
    exp_s = 16'sd16383;
`endif
    send_one(16'sd16384, 16'sd0, 16'sd32767, 16'sd0, 1'b0);
    n_checks++;
    if (out_valid_s !== 1'b1 || ys_re !== exp_s || ys_im !== 16'sd0) begin
      n_fail++;
      $display("FAIL scaling_re: valid=%b y=(%0d,%0d) expected 1,(%0d,0)", out_valid_s, ys_re, ys_im, exp_s);
    end
    n_checks++;
    if (longint'(y_re) !== 64'sd536854528) begin
      n_fail++;
      $display("FAIL scaling_full_precision: got %0d expected 536854528", y_re);
    end
  endtask

  task automatic test_stream_random;
    longint er, ei;
    exp_re_q.delete(); exp_im_q.delete();
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 104; i++) begin
      out_ready = 1'b1;
      if (i < 100) begin
        in_valid = 1'b1;
        set_in(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), i[0]);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i >= 2 && i < 102) begin
        n_checks++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_rate: cycle %0d out_valid=%b expected 1", i, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_re_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_extra: unexpected output (%0d,%0d) expected none", y_re, y_im);
        end else begin
          er = exp_re_q.pop_front();
          ei = exp_im_q.pop_front();
          if (longint'(y_re) !== er || longint'(y_im) !== ei) begin
            n_fail++;
            $display("FAIL stream_data: got (%0d,%0d) expected (%0d,%0d)", y_re, y_im, er, ei);
          end
        end
      end
      if (in_valid && in_ready) begin
        model(a_re, a_im, b_re, b_im, in_conj, er, ei);
        exp_re_q.push_back(er);
        exp_im_q.push_back(ei);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (exp_re_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_drain: %0d results missing expected 0", exp_re_q.size());
    end
  endtask

  task automatic test_backpressure;
    longint er, ei;
    int accepted, drained;
    logic exp_rdy, prev_hold;
    logic signed [32:0] prev_re, prev_im;
    logic signed [15:0] sa_re, sa_im, sb_re, sb_im;
    logic sc;
    exp_re_q.delete(); exp_im_q.delete();
    accepted = 0; drained = 0; prev_hold = 1'b0; prev_re = '0; prev_im = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    sa_re = 16'($urandom); sa_im = 16'($urandom); sb_re = 16'($urandom); sb_im = 16'($urandom); sc = 1'b0;
    for (int cyc = 0; cyc < 200 && drained < 10; cyc++) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (accepted < 10);
      set_in(sa_re, sa_im, sb_re, sb_im, sc);
      #1;
      if (prev_hold) begin
        n_checks++;
        if (out_valid !== 1'b1 || y_re !== prev_re || y_im !== prev_im) begin
          n_fail++;
          $display("FAIL bp_hold: valid=%b y=(%0d,%0d) expected 1,(%0d,%0d)", out_valid, y_re, y_im, prev_re, prev_im);
        end
      end
      exp_rdy = !(exp_re_q.size() == 2 && !out_ready);
      n_checks++;
      if (in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL bp_in_ready: cycle %0d got %b expected %b", cyc, in_ready, exp_rdy);
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_re_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra: unexpected output (%0d,%0d) expected none", y_re, y_im);
        end else begin
          er = exp_re_q.pop_front();
          ei = exp_im_q.pop_front();
          drained++;
          if (longint'(y_re) !== er || longint'(y_im) !== ei) begin
            n_fail++;
            $display("FAIL bp_data: got (%0d,%0d) expected (%0d,%0d)", y_re, y_im, er, ei);
          end
        end
      end
      if (in_valid && in_ready) begin
        model(sa_re, sa_im, sb_re, sb_im, sc, er, ei);
        exp_re_q.push_back(er);
        exp_im_q.push_back(ei);
        accepted++;
        sa_re = 16'($urandom); sa_im = 16'($urandom); sb_re = 16'($urandom); sb_im = 16'($urandom);
        sc = ~sc;
      end
      prev_hold = out_valid && !out_ready;
      prev_re   = y_re;
      prev_im   = y_im;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (drained != 10 || exp_re_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_count: drained %0d pending %0d expected 10 and 0", drained, exp_re_q.size());
    end
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_in(16'sd11, -16'sd7, 16'sd9, 16'sd2, 1'b0);
    @(posedge clk); #1;
    set_in(-16'sd5, 16'sd6, 16'sd1, -16'sd3, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_full: in_ready=%b out_valid=%b expected 0,1", in_ready, out_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || y_re !== 33'sd0 || y_im !== 33'sd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_clear: valid=%b y=(%0d,%0d) in_ready=%b expected 0,(0,0),1", out_valid, y_re, y_im, in_ready);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || y_re !== 33'sd0) begin
        n_fail++;
        $display("FAIL midreset_stale: cycle %0d valid=%b y_re=%0d expected 0,0", i, out_valid, y_re);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_conj();
    test_corner();
    test_scaling();
    test_stream_random();
    test_backpressure();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
